vga_scan_ctrl: RTL and testbench
================================

# vga_scan_ctrl

Scan sequencer for the Snake VGA path. It consumes the 25 MHz pixel-enable strobe generated from the 100 MHz system clock and steps the horizontal and vertical scan counters. From those counters it produces registered hsync, vsync, active-video, pixel coordinates, a vertical-blank-start pulse and a paused-able game-step tick. It sits between the pixel-strobe divider and the snake renderer/game-state logic; everything runs in the `clk` domain, with `pix_stb` used as an enable, never as a clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- TICK_FRAMES, 6, frames per game step; legal range 1..255
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- pix_stb  in  1  pixel enable; the scan advances one pixel on each clk edge where it is 1
- pause  in  1  high = suppress game_tick; video timing unaffected
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- active  out  1  1 while the scan position is in the visible area
- x  out  10  pixel column; valid when active=1, 0 otherwise
- y  out  10  pixel row; valid when active=1, 0 otherwise
- vblank_start  out  1  one-clk pulse when the scan enters line V_ACTIVE, column 0
- game_tick  out  1  one-clk pulse marking a game-state update slot

## Operation
- Constants: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800); V_TOTAL = 525. The counters are 10 bits each.
- Scan counters:
  - h_cnt runs 0..H_TOTAL-1.
  - v_cnt runs 0..V_TOTAL-1 and advances when h_cnt wraps.
  - (H_TOTAL-1, V_TOTAL-1) wraps to (0,0).
  - Neither counter changes on cycles with pix_stb=0.
- Decodes:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - x = h_cnt and y = v_cnt when active, else 0.
- All outputs are registers. They are loaded from the next-state counter values, so in every cycle the outputs describe the current counter position with zero lag and no combinational glitches.
- vblank_start = 1 for exactly the clk cycle in which the counters hold (0, V_ACTIVE). It is asserted only after a pix_stb advance into that position.
- Frame divider (frm_cnt, 8 bit, range 0..TICK_FRAMES-1), evaluated on each vblank_start:
  - If pause=1: frm_cnt holds and game_tick stays 0.
  - Else if frm_cnt == TICK_FRAMES-1: game_tick is pulsed in the same cycle as vblank_start, and frm_cnt returns to 0.
  - Else: frm_cnt increments by 1.
  - pause is sampled only in vblank_start cycles.
- Reset:
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so the first strobe lands on (0,0).
  - hsync = 1, vsync = 1, active = 0, x = 0, y = 0, vblank_start = 0, game_tick = 0, frm_cnt = 0.
  - Reset asserted mid-line or mid-frame restores this state on the next edge, with no pulses emitted.
  - Reset has priority over pix_stb.

## Timing
- Latency: an edge with pix_stb=1 updates every output on that same edge (outputs become visible in the following cycle).
- pix_stb may be continuous (advance every clk), periodic (every 4th clk nominally), or irregular. Behaviour is defined per strobe, not per clk.
- First strobe after reset: active=1, x=0, y=0.
- vblank_start first fires on strobe 384001 after reset (480×800+1), then every 420000 strobes.
- game_tick and vblank_start are never wider than 1 clk, even when pix_stb is held high.
- Sync-width parameters set to 0 are illegal and unsupported.

## Test plan
- Reset, then 10 idle cycles with pix_stb=0 -> hsync=1, vsync=1, active=0, x=y=0, no pulses. First strobe -> active=1, x=0, y=0.
- pix_stb every 4th clk, count strobes from reset:
  - hsync goes low on strobe 657 and high on strobe 753.
  - active drops on strobe 641.
  - y=1, x=0 on strobe 801.
- Full frame with continuous pix_stb:
  - vsync is low for exactly 1600 strobes, starting at v_cnt=490.
  - vblank_start fires at strobes 384001 and 804001.
  - Counters are back at (0,0) at strobe 420001.
- TICK_FRAMES=3, pause=0, 7 frames -> game_tick coincides with the 3rd and 6th vblank_start only.
- TICK_FRAMES=3, pause=1 during vblank 2 and released before vblank 3 -> ticks occur at vblanks 4 and 7.
- Reset asserted at (x=300, y=200) for 1 clk -> next strobe yields (0,0), active=1, no vblank_start or game_tick; frm_cnt restarts from 0.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer: steps h/v counters on pix_stb and decodes sync, active, coordinates, vblank and game tick.
// Latency: every output is loaded from the next-state counters, so it reflects the new position right after the strobe edge.
// Backpressure: none; pix_stb is a free-running enable and the block accepts every strobe.
module vga_scan_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int TICK_FRAMES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_stb,
    input  logic       pause,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vblank_start,
    output logic       game_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0] FRM_LAST   = 8'(TICK_FRAMES - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [7:0] frm_cnt_q, frm_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       active_q, active_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       vblank_start_q, vblank_start_d;
    logic       game_tick_q, game_tick_d;

    // Next scan position: advance one pixel per strobe, wrapping line then frame.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_stb) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Decode outputs from the next position so registered outputs carry no lag.
    always_comb begin
        active_d       = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
        hsync_d        = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
        vsync_d        = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
        x_d            = active_d ? h_cnt_d : '0;
        y_d            = active_d ? v_cnt_d : '0;
        // Only a strobe can move into (0, V_ACTIVE), which keeps this a single-clk pulse.
        vblank_start_d = pix_stb && (h_cnt_d == '0) && (v_cnt_d == V_ACT);
    end

    // Frame divider: count vblanks and emit a game tick every TICK_FRAMES unpaused frames.
    always_comb begin
        frm_cnt_d   = frm_cnt_q;
        game_tick_d = 1'b0;
        if (vblank_start_d && !pause) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d   = '0;
                game_tick_d = 1'b1;
            end else begin
                frm_cnt_d = frm_cnt_q + 8'd1;
            end
        end
    end

    // State and output registers; reset parks the scan one pixel before (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q        <= H_LAST;
            v_cnt_q        <= V_LAST;
            frm_cnt_q      <= '0;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
            active_q       <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            vblank_start_q <= 1'b0;
            game_tick_q    <= 1'b0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            frm_cnt_q      <= frm_cnt_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            active_q       <= active_d;
            x_q            <= x_d;
            y_q            <= y_d;
            vblank_start_q <= vblank_start_d;
            game_tick_q    <= game_tick_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign active       = active_q;
    assign x            = x_q;
    assign y            = y_q;
    assign vblank_start = vblank_start_q;
    assign game_tick    = game_tick_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: full-size instance for line timing, shrunken instance for frame/tick behaviour.
// Reference model derives position from the strobe count since reset.
// Stimulus mixes fixed strobe patterns with $urandom strobes and pause.
module tb_vga_scan_ctrl;

    localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VB = 33, A_TF = 6;
    localparam int A_HT = A_HA + A_HFP + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VFP + A_VS + A_VB;

    localparam int B_HA = 16, B_HFP = 2, B_HS = 3, B_HB = 3;
    localparam int B_VA = 8,  B_VFP = 2, B_VS = 2, B_VB = 2, B_TF = 3;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VB;
    localparam int B_FRAME = B_HT * B_VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
        logic       vb;
        logic       gt;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, stb_a = 1'b0, pause_a = 1'b0;
    logic       hs_a, vs_a, act_a, vb_a_o, gt_a_o;
    logic [9:0] x_a, y_a;
    logic       rst_b = 1'b1, stb_b = 1'b0, pause_b = 1'b0;
    logic       hs_b, vs_b, act_b, vb_b_o, gt_b_o;
    logic [9:0] x_b, y_b;

    vga_scan_ctrl #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VB), .TICK_FRAMES(A_TF)
    ) dut_a (
        .clk(clk), .rst(rst_a), .pix_stb(stb_a), .pause(pause_a),
        .hsync(hs_a), .vsync(vs_a), .active(act_a), .x(x_a), .y(y_a),
        .vblank_start(vb_a_o), .game_tick(gt_a_o)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VB), .TICK_FRAMES(B_TF)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_stb(stb_b), .pause(pause_b),
        .hsync(hs_b), .vsync(vs_b), .active(act_b), .x(x_b), .y(y_b),
        .vblank_start(vb_b_o), .game_tick(gt_b_o)
    );

    int checks = 0;
    int passed = 0;

    // Reference model state: strobes since reset, frame divider, pulses of the last edge.
    int n_a = 0, frm_a = 0;
    bit mvb_a = 0, mgt_a = 0;
    int n_b = 0, frm_b = 0;
    bit mvb_b = 0, mgt_b = 0;

    function automatic out_t expect_out(int n, bit vb, bit gt, int ha, int hfp, int hsw, int hbp,
                                        int va, int vfp, int vsw, int vbp);
        out_t o;
        int ht, vt, p, h, v;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        o.hs = 1'b1; o.vs = 1'b1; o.act = 1'b0; o.x = '0; o.y = '0;
        o.vb = vb; o.gt = gt;
        if (n > 0) begin
            p = (n - 1) % (ht * vt);
            h = p % ht;
            v = p / ht;
            o.act = (h < ha) && (v < va);
            o.hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
            o.vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
            if (o.act) begin
                o.x = 10'(h);
                o.y = 10'(v);
            end
        end
        return o;
    endfunction

    // Strobe n lands on the linear position n-1; vblank starts at linear position va*ht.
    function automatic bit lands_on_vblank(int n, int ht, int vt, int va);
        return ((n - 1) % (ht * vt)) == va * ht;
    endfunction

    function automatic out_t exp_a();
        return expect_out(n_a, mvb_a, mgt_a, A_HA, A_HFP, A_HS, A_HB, A_VA, A_VFP, A_VS, A_VB);
    endfunction

    function automatic out_t exp_b();
        return expect_out(n_b, mvb_b, mgt_b, B_HA, B_HFP, B_HS, B_HB, B_VA, B_VFP, B_VS, B_VB);
    endfunction

    function automatic out_t obs_a();
        out_t o;
        o.hs = hs_a; o.vs = vs_a; o.act = act_a; o.x = x_a; o.y = y_a; o.vb = vb_a_o; o.gt = gt_a_o;
        return o;
    endfunction

    function automatic out_t obs_b();
        out_t o;
        o.hs = hs_b; o.vs = vs_b; o.act = act_b; o.x = x_b; o.y = y_b; o.vb = vb_b_o; o.gt = gt_b_o;
        return o;
    endfunction

    // One clk on instance A: drive strobe, take the edge, update the model, settle.
    task automatic adv_a(input bit s);
        stb_a = s;
        @(posedge clk);
        mvb_a = 0;
        mgt_a = 0;
        if (rst_a) begin
            n_a = 0;
            frm_a = 0;
        end else if (s) begin
            n_a++;
            if (lands_on_vblank(n_a, A_HT, A_VT, A_VA)) begin
                mvb_a = 1;
                if (!pause_a) begin
                    if (frm_a == A_TF - 1) begin mgt_a = 1; frm_a = 0; end
                    else frm_a++;
                end
            end
        end
        #1;
    endtask

    task automatic adv_b(input bit s);
        stb_b = s;
        @(posedge clk);
        mvb_b = 0;
        mgt_b = 0;
        if (rst_b) begin
            n_b = 0;
            frm_b = 0;
        end else if (s) begin
            n_b++;
            if (lands_on_vblank(n_b, B_HT, B_VT, B_VA)) begin
                mvb_b = 1;
                if (!pause_b) begin
                    if (frm_b == B_TF - 1) begin mgt_b = 1; frm_b = 0; end
                    else frm_b++;
                end
            end
        end
        #1;
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        adv_b(1'b0);
        adv_b(1'b0);
        rst_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        adv_a(1'b0);
        adv_a(1'b1);  // strobe during reset must be ignored
        checks++;
        if (obs_a() !== exp_a()) $display("FAIL reset_state got=%h exp=%h", obs_a(), exp_a());
        else passed++;
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adv_a(1'b0);
            checks++;
            if (obs_a() !== exp_a()) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_a(), exp_a());
            else passed++;
        end
        adv_a(1'b1);
        checks++;
        if (!(act_a === 1'b1 && x_a === 10'd0 && y_a === 10'd0))
            $display("FAIL first_strobe act=%b x=%0d y=%0d exp act=1 x=0 y=0", act_a, x_a, y_a);
        else passed++;
    endtask

    task automatic test_line_timing();
        int cyc;
        bit s;
        logic hs656, hs657, hs752, hs753, act640, act641;
        logic [9:0] x801, y801;
        cyc = 0;
        while (n_a < 805) begin
            s = (cyc % 4 == 3);
            cyc++;
            adv_a(s);
            checks++;
            if (obs_a() !== exp_a()) $display("FAIL line_model n=%0d got=%h exp=%h", n_a, obs_a(), exp_a());
            else passed++;
            if (s) begin
                if (n_a == 640) act640 = act_a;
                if (n_a == 641) act641 = act_a;
                if (n_a == 656) hs656 = hs_a;
                if (n_a == 657) hs657 = hs_a;
                if (n_a == 752) hs752 = hs_a;
                if (n_a == 753) hs753 = hs_a;
                if (n_a == 801) begin x801 = x_a; y801 = y_a; end
            end
        end
        checks++;
        if (!(hs656 === 1'b1 && hs657 === 1'b0)) $display("FAIL hsync_fall s656=%b s657=%b exp 1,0", hs656, hs657);
        else passed++;
        checks++;
        if (!(hs752 === 1'b0 && hs753 === 1'b1)) $display("FAIL hsync_rise s752=%b s753=%b exp 0,1", hs752, hs753);
        else passed++;
        checks++;
        if (!(act640 === 1'b1 && act641 === 1'b0)) $display("FAIL active_drop s640=%b s641=%b exp 1,0", act640, act641);
        else passed++;
        checks++;
        if (!(x801 === 10'd0 && y801 === 10'd1)) $display("FAIL line_wrap x=%0d y=%0d exp x=0 y=1", x801, y801);
        else passed++;
    endtask

    task automatic test_irregular();
        for (int i = 0; i < 3000; i++) begin
            adv_a($urandom_range(0, 2) == 0);
            checks++;
            if (obs_a() !== exp_a()) $display("FAIL irregular n=%0d got=%h exp=%h", n_a, obs_a(), exp_a());
            else passed++;
        end
    endtask

    task automatic test_full_frame();
        int vs_low, first_low;
        int vbq[$];
        logic [9:0] x_w, y_w;
        logic act_w;
        vs_low = 0;
        first_low = 0;
        reset_b();
        while (n_b < 2 * B_FRAME + 5) begin
            adv_b(1'b1);
            checks++;
            if (obs_b() !== exp_b()) $display("FAIL frame_model n=%0d got=%h exp=%h", n_b, obs_b(), exp_b());
            else passed++;
            if (n_b <= B_FRAME && vs_b === 1'b0) begin
                vs_low++;
                if (first_low == 0) first_low = n_b;
            end
            if (vb_b_o === 1'b1) vbq.push_back(n_b);
            if (n_b == B_FRAME + 1) begin x_w = x_b; y_w = y_b; act_w = act_b; end
        end
        checks++;
        if (vs_low !== B_VS * B_HT) $display("FAIL vsync_width got=%0d exp=%0d", vs_low, B_VS * B_HT);
        else passed++;
        checks++;
        if (first_low !== (B_VA + B_VFP) * B_HT + 1) $display("FAIL vsync_start got=%0d exp=%0d", first_low, (B_VA + B_VFP) * B_HT + 1);
        else passed++;
        checks++;
        if (vbq.size() !== 2) $display("FAIL vblank_count got=%0d exp=2", vbq.size());
        else if (vbq[0] !== B_VA * B_HT + 1 || vbq[1] !== B_VA * B_HT + 1 + B_FRAME)
            $display("FAIL vblank_strobes got=%0d,%0d exp=%0d,%0d", vbq[0], vbq[1], B_VA * B_HT + 1, B_VA * B_HT + 1 + B_FRAME);
        else passed++;
        checks++;
        if (!(x_w === 10'd0 && y_w === 10'd0 && act_w === 1'b1))
            $display("FAIL frame_wrap x=%0d y=%0d act=%b exp 0,0,1", x_w, y_w, act_w);
        else passed++;
    endtask

    // Runs until the given number of vblanks; pause_mode 1 pauses only across vblank 2.
    task automatic run_ticks(input string tag, input int frames, input bit pause_mode, output int tq[$]);
        int vbn;
        vbn = 0;
        tq.delete();
        while (vbn < frames) begin
            adv_b(1'b1);
            checks++;
            if (obs_b() !== exp_b()) $display("FAIL %s n=%0d got=%h exp=%h", tag, n_b, obs_b(), exp_b());
            else passed++;
            if (vb_b_o === 1'b1) vbn++;
            if (gt_b_o === 1'b1) tq.push_back(vbn);
            if (n_b > (frames + 1) * B_FRAME) vbn = frames;  // bound if vblank never shows
            pause_b = pause_mode && (vbn == 1);
        end
        pause_b = 1'b0;
    endtask

    task automatic test_ticks();
        int tq[$];
        reset_b();
        pause_b = 1'b0;
        run_ticks("tick_model", 7, 1'b0, tq);
        checks++;
        if (tq.size() !== 2) $display("FAIL tick_count got=%0d exp=2", tq.size());
        else if (tq[0] !== 3 || tq[1] !== 6) $display("FAIL tick_slots got=%0d,%0d exp=3,6", tq[0], tq[1]);
        else passed++;
    endtask

    task automatic test_pause();
        int tq[$];
        reset_b();
        run_ticks("pause_model", 7, 1'b1, tq);
        checks++;
        if (tq.size() !== 2) $display("FAIL pause_tick_count got=%0d exp=2", tq.size());
        else if (tq[0] !== 4 || tq[1] !== 7) $display("FAIL pause_tick_slots got=%0d,%0d exp=4,7", tq[0], tq[1]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int tq[$];
        reset_b();
        // past one vblank so the divider is non-zero, then stop at (x=5, y=3) of frame 2
        while (n_b < B_FRAME + 3 * B_HT + 6) begin
            adv_b(1'b1);
            checks++;
            if (obs_b() !== exp_b()) $display("FAIL midrst_pre n=%0d got=%h exp=%h", n_b, obs_b(), exp_b());
            else passed++;
        end
        rst_b = 1'b1;
        adv_b(1'b1);
        rst_b = 1'b0;
        checks++;
        if (obs_b() !== exp_b()) $display("FAIL midrst_state got=%h exp=%h", obs_b(), exp_b());
        else passed++;
        adv_b(1'b1);
        checks++;
        if (!(x_b === 10'd0 && y_b === 10'd0 && act_b === 1'b1 && vb_b_o === 1'b0 && gt_b_o === 1'b0))
            $display("FAIL midrst_first x=%0d y=%0d act=%b vb=%b gt=%b exp 0,0,1,0,0", x_b, y_b, act_b, vb_b_o, gt_b_o);
        else passed++;
        run_ticks("midrst_model", 3, 1'b0, tq);
        checks++;
        if (tq.size() !== 1 || tq[0] !== 3) $display("FAIL midrst_divider ticks=%0d exp one tick at vblank 3", tq.size());
        else passed++;
    endtask

    task automatic test_random();
        bit s;
        reset_b();
        for (int i = 0; i < 6000; i++) begin
            s = ($urandom_range(0, 1) == 1);
            adv_b(s);
            checks++;
            if (obs_b() !== exp_b()) $display("FAIL random n=%0d got=%h exp=%h", n_b, obs_b(), exp_b());
            else passed++;
            // change pause only at the top of a frame, far from any vblank edge
            if (s && ((n_b - 1) % B_FRAME) == 0) pause_b = ($urandom_range(0, 2) == 0);
        end
        pause_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_irregular();
        test_full_frame();
        test_ticks();
        test_pause();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
